// File: rtl/alu_mdu.sv
// RV32 execute unit: single-cycle ALU and branch comparator plus an iterative
// shift-add multiplier and restoring divider, behind valid/ready handshakes.
module alu_mdu #(
  parameter int XLEN = 32,
  parameter bit EN_M = 1'b1
) (
  input  logic            clk,
  input  logic            n_rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] src_A,
  input  logic [XLEN-1:0] src_B,
  input  logic [31:0]     instruction,
  input  logic [1:0]      ALU_control,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] ALU_result,
  output logic            BranchConditionFlag,
  output logic            illegal,
  output logic            busy
);

  localparam int SHW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
  state_t state, state_nxt, start_state;

  logic [6:0]      opcode, funct7;
  logic [2:0]      funct3;
  logic [SHW-1:0]  shamt;
  logic            is_r, is_i, is_m, alu_legal, do_sub, do_sra, div_ovf;
  logic            accept, last;
  logic [XLEN-1:0] sc_result;
  logic            sc_flag, sc_illegal, go_mul, go_div;
  logic            unused_bits;

  logic [2*XLEN-1:0] acc, mcand, add_term, acc_nxt, mcand_init;
  logic [XLEN-1:0]   mplier, mul_res;
  logic              mul_hi, mul_neg_last;
  logic [XLEN-1:0]   rem_r, quo_r, dvsr, rem_nxt, quo_nxt, div_res, mag_a, mag_b;
  logic [XLEN:0]     shifted, diff;
  logic              neg_q, neg_r, want_rem, a_neg, b_neg, a_sx;
  logic [SHW-1:0]    cnt;

  assign opcode      = instruction[6:0];
  assign funct3      = instruction[14:12];
  assign funct7      = instruction[31:25];
  assign unused_bits = ^instruction[24:15];
  assign shamt       = src_B[SHW-1:0];
  assign is_r        = (opcode == 7'b0110011);
  assign is_i        = (opcode == 7'b0010011);
  assign is_m        = (ALU_control == 2'b00) && is_r && (funct7 == 7'b0000001);
  assign do_sub      = is_r && funct7[5];
  assign do_sra      = funct7[5];
  assign div_ovf     = !funct3[0] && (src_A == MIN_VAL) && (src_B == '1);

  assign in_ready  = !flush && ((state == IDLE) || ((state == DONE) && out_ready));
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == DONE);
  assign busy      = (state == MUL) || (state == DIV);
  assign last      = (cnt == {SHW{1'b1}});

  always_comb begin
    alu_legal = 1'b1;
    if (is_r) begin
      alu_legal = (funct7 == 7'b0000000) ||
                  ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
    end else if (is_i) begin
      if (funct3 == 3'b001)      alu_legal = (funct7 == 7'b0000000);
      else if (funct3 == 3'b101) alu_legal = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
    end
  end

  // Single-cycle result and the decision whether to start an iterative op
  always_comb begin
    sc_result  = '0;
    sc_flag    = 1'b0;
    sc_illegal = 1'b0;
    go_mul     = 1'b0;
    go_div     = 1'b0;
    case (ALU_control)
      2'b00: begin
        if (is_m) begin
          if (!EN_M)                sc_illegal = 1'b1;
          else if (!funct3[2])      go_mul = 1'b1;
          else if (src_B == '0)     sc_result = funct3[1] ? src_A : '1;
          else if (div_ovf)         sc_result = funct3[1] ? '0 : MIN_VAL;
          else                      go_div = 1'b1;
        end else if (is_r || is_i) begin
          case (funct3)
            3'b000: sc_result = do_sub ? (src_A - src_B) : (src_A + src_B);
            3'b001: sc_result = src_A << shamt;
            3'b010: sc_result = {{(XLEN-1){1'b0}}, ($signed(src_A) < $signed(src_B))};
            3'b011: sc_result = {{(XLEN-1){1'b0}}, (src_A < src_B)};
            3'b100: sc_result = src_A ^ src_B;
            3'b101: begin
              if (do_sra) sc_result = $unsigned($signed(src_A) >>> shamt);
              else        sc_result = src_A >> shamt;
            end
            3'b110: sc_result = src_A | src_B;
            default: sc_result = src_A & src_B;
          endcase
          if (!alu_legal) begin
            sc_result  = '0;
            sc_illegal = 1'b1;
          end
        end else begin
          sc_illegal = 1'b1;
        end
      end
      2'b01: begin
        case (funct3)
          3'b000:  sc_flag = (src_A == src_B);
          3'b001:  sc_flag = (src_A != src_B);
          3'b100:  sc_flag = ($signed(src_A) < $signed(src_B));
          3'b101:  sc_flag = !($signed(src_A) < $signed(src_B));
          3'b110:  sc_flag = (src_A < src_B);
          3'b111:  sc_flag = !(src_A < src_B);
          default: sc_illegal = 1'b1;
        endcase
      end
      2'b10:   sc_result = src_A + src_B;
      default: sc_result = src_B;
    endcase
  end

  // Operand preparation at accept: sign extension for MUL, magnitudes for DIV
  always_comb begin
    a_sx       = ((funct3 == 3'b001) || (funct3 == 3'b010)) && src_A[XLEN-1];
    mcand_init = {{XLEN{a_sx}}, src_A};
    a_neg      = !funct3[0] && src_A[XLEN-1];
    b_neg      = !funct3[0] && src_B[XLEN-1];
    mag_a      = a_neg ? -src_A : src_A;
    mag_b      = b_neg ? -src_B : src_B;
  end

  // One iteration step; the signed multiplier's top bit carries negative weight
  always_comb begin
    add_term = mplier[0] ? mcand : '0;
    acc_nxt  = (last && mul_neg_last) ? (acc - add_term) : (acc + add_term);
    mul_res  = mul_hi ? acc_nxt[2*XLEN-1:XLEN] : acc_nxt[XLEN-1:0];
    shifted  = {rem_r, quo_r[XLEN-1]};
    diff     = shifted - {1'b0, dvsr};
    if (diff[XLEN]) begin
      rem_nxt = shifted[XLEN-1:0];
      quo_nxt = {quo_r[XLEN-2:0], 1'b0};
    end else begin
      rem_nxt = diff[XLEN-1:0];
      quo_nxt = {quo_r[XLEN-2:0], 1'b1};
    end
    if (want_rem) div_res = neg_r ? -rem_nxt : rem_nxt;
    else          div_res = neg_q ? -quo_nxt : quo_nxt;
  end

  always_comb begin
    start_state = DONE;
    if (go_mul)      start_state = MUL;
    else if (go_div) start_state = DIV;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = start_state;
      MUL,
      DIV:     if (last) state_nxt = DONE;
      default: if (out_ready) state_nxt = accept ? start_state : IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      acc          <= '0;
      mcand        <= '0;
      mplier       <= '0;
      mul_hi       <= 1'b0;
      mul_neg_last <= 1'b0;
      rem_r        <= '0;
      quo_r        <= '0;
      dvsr         <= '0;
      neg_q        <= 1'b0;
      neg_r        <= 1'b0;
      want_rem     <= 1'b0;
      cnt          <= '0;
    end else if (accept) begin
      acc          <= '0;
      mcand        <= mcand_init;
      mplier       <= src_B;
      mul_hi       <= (funct3 != 3'b000);
      mul_neg_last <= (funct3 == 3'b001);
      rem_r        <= '0;
      quo_r        <= mag_a;
      dvsr         <= mag_b;
      neg_q        <= a_neg ^ b_neg;
      neg_r        <= a_neg;
      want_rem     <= funct3[1];
      cnt          <= '0;
    end else if (state == MUL) begin
      acc    <= acc_nxt;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
    end else if (state == DIV) begin
      rem_r <= rem_nxt;
      quo_r <= quo_nxt;
      cnt   <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      ALU_result          <= '0;
      BranchConditionFlag <= 1'b0;
      illegal             <= 1'b0;
    end else if (accept && !go_mul && !go_div) begin
      ALU_result          <= sc_result;
      BranchConditionFlag <= sc_flag;
      illegal             <= sc_illegal;
    end else if (busy && last && !flush) begin
      ALU_result          <= (state == MUL) ? mul_res : div_res;
      BranchConditionFlag <= 1'b0;
      illegal             <= 1'b0;
    end
  end

endmodule

// File: doc/alu_mdu.md
# alu_mdu

Sequential, parametrised execute unit for the team's RV32 core. It combines the base-integer ALU and branch comparator with an iterative multiply/divide unit covering the M extension. Operands are accepted over a valid/ready handshake, and results are held in an output register until consumed. It sits between the decode/register-read stage and writeback/branch resolution.

## Interface
- XLEN, 32: datapath width; must be a power of two, at least 8.
- EN_M, 1: 1 = M-extension ops execute. 0 = M-extension ops return 0 with `illegal` = 1, latency 1.
- SHW, $clog2(XLEN): shift-amount width (localparam).

Ports:
- clk  in  1  rising-edge clock
- n_rst  in  1  asynchronous active-low reset
- flush  in  1  synchronous cancel of any operation in flight or held
- in_valid  in  1  operands/instruction valid
- in_ready  out  1  unit can accept this cycle
- src_A  in  XLEN  operand A (rs1)
- src_B  in  XLEN  operand B (rs2 or immediate)
- instruction  in  32  raw instruction; uses opcode[6:0], funct3[14:12], funct7[31:25]
- ALU_control  in  2  00 = R/I-type via funct3/funct7; 01 = branch compare; 10 = ADD (address); 11 = pass src_B (LUI)
- out_valid  out  1  result register valid
- out_ready  in  1  consumer takes result
- ALU_result  out  XLEN  registered result
- BranchConditionFlag  out  1  registered branch decision
- illegal  out  1  registered; op undefined, or EN_M = 0 with an M op
- busy  out  1  multi-cycle op in progress

## Operation
- States: IDLE, MUL, DIV, DONE. Accept = in_valid & in_ready.
- in_ready = (state == IDLE) | (state == DONE & out_ready).
- ALU_control 00, opcode 0110011, funct7 = 0000001 is an M op:
  - funct3 0–3 (MUL, MULH, MULHSU, MULHU) go to MUL.
  - funct3 4–7 (DIV, DIVU, REM, REMU) go to DIV.
- All other encodings are single-cycle and go straight to DONE.
- funct7[5] selects SUB/SRA only when opcode = 0110011 (SUB) or funct3 = 101 (SRA). I-type ADDI never subtracts.
- Shifts use src_B[SHW-1:0] only. SLT/SLTU produce 1 or 0, zero-extended.
- Branch compare (ALU_control 01):
  - funct3 000 = BEQ, 001 = BNE, 100 = BLT, 101 = BGE, 110 = BLTU, 111 = BGEU.
  - funct3 010/011 give flag 0 and illegal 1.
  - ALU_result = 0.
- BranchConditionFlag is 0 for every non-branch op.
- Multiplier:
  - Radix-2 shift-add on a 2·XLEN accumulator, XLEN iterations.
  - Operands are sign- or zero-extended per the MULH/MULHSU/MULHU signedness.
  - MUL returns the low XLEN bits; the MULH variants return the high XLEN bits.
- Divider:
  - Restoring, XLEN iterations, on magnitudes; signs are fixed up at the end.
  - Remainder takes the sign of the dividend.
- Divide fast paths (1 cycle, no DIV state):
  - src_B = 0: quotient = all ones, remainder = src_A.
  - Signed src_A = MIN with src_B = −1: quotient = MIN, remainder = 0.
- DONE holds ALU_result, BranchConditionFlag and illegal stable until out_ready.
- Operands are captured at accept. Input changes after accept have no effect.

## Timing
- Reset (n_rst low, async):
  - state = IDLE.
  - out_valid, ALU_result, BranchConditionFlag, illegal and busy all 0.
  - in_ready = 1 once reset is released.
- Single-cycle op accepted in cycle N: out_valid = 1 in cycle N+1.
- MUL/DIV accepted in cycle N: busy = 1 in cycles N+1 … N+XLEN, out_valid = 1 in cycle N+XLEN+1.
- The result is retired on the cycle where out_valid & out_ready.
- Back-to-back: when DONE & out_ready & in_valid, a new op is accepted in the same cycle.
  - A new single-cycle result is valid the next cycle, so there is no bubble.
- out_valid & !out_ready: the output holds indefinitely and in_ready = 0.
- flush:
  - Next state = IDLE, and out_valid = 0 the next cycle.
  - An iteration in progress is discarded.
  - flush wins over a simultaneous accept: the op is dropped.
  - in_ready is forced to 0 during the flush cycle.
- n_rst asserted mid-iteration: immediate return to the reset values. Nothing is produced for the aborted op.

## Test plan
- Single-cycle ops:
  - ADD 10 + 15 → 25.
  - SUB 15 − 10 → 5.
  - SRA 0xF0000000 by 4 → 0xFF000000.
  - SLTU 1 vs 0xFFFFFFFF → 1.
  - Each has out_valid exactly 1 cycle after accept and stays back-to-back with out_ready held at 1.
- Branches:
  - BEQ 42, 42 → flag 1.
  - BLT −5, 2 → flag 1.
  - BGEU 1, 0xFFFFFFFF → flag 0.
  - funct3 010 → flag 0, illegal 1.
- Multiply, each with out_valid at accept + 33 when XLEN = 32:
  - MUL 0xFFFFFFFF × 0xFFFFFFFF → 0x00000001.
  - MULHU of the same operands → 0xFFFFFFFE.
  - MULH −2 × 3 → 0xFFFFFFFF.
- Divide:
  - DIV −7 / 2 → 0xFFFFFFFD.
  - REM −7 / 2 → 0xFFFFFFFF.
  - DIVU 7 / 0 → 0xFFFFFFFF at accept + 1.
  - DIV 0x80000000 / −1 → 0x80000000 at accept + 1.
- Backpressure:
  - Hold out_ready = 0 for 5 cycles after a MUL completes.
  - Result stays stable and in_ready stays 0.
  - Release out_ready with in_valid high: the next op is accepted in the same cycle.
- Flush and reset:
  - Assert flush 10 cycles into a DIV: out_valid never rises and the unit is IDLE the next cycle.
  - Pull n_rst low mid-MUL: all outputs go to 0 asynchronously.
  - Rerun with XLEN = 16: MUL latency is 17 cycles.
